// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage CPU: arbiter FSM encoding,
// error read-back pattern and load/store opcodes.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_D = 2'd1,
      BUSY_I = 2'd2
   } arb_state_t;

   localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

   localparam logic [6:0] LW = 7'b0000011;
   localparam logic [6:0] SW = 7'b0100011;

endpackage

// File: rtl/arb_timeout_counter.sv
// Per-transaction wait counter; flags expiry on the TIMEOUT-th
// consecutive enabled cycle without a clear.
module arb_timeout_counter #(
   parameter int TIMEOUT = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_cnt;

   assign expired = en & (r_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the single-ported unified memory between IF and MEM,
// generating the global stall and error pulses.
module unified_mem_arbiter
   import cpu_pkg::*;
#(
   parameter int          ADDR_W   = 10,
   parameter int          TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_valid,
   input  logic              flush,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [31:0]       dm_addr,
   input  logic [31:0]       dm_wdata,
   output logic [31:0]       dm_rdata,
   output logic              dm_valid,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic              err_misalign,
   output logic              err_timeout,
   output logic [31:0]       stall_cnt
);

   arb_state_t r_state, w_next;

   logic              r_if_done, r_dm_done, r_drop;
   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic [31:0]       r_wdata, r_if_rdata, r_dm_rdata;
   logic              r_err_mis, r_err_to;
   logic [31:0]       r_stall_cnt;

   logic w_busy, w_if_pend, w_dm_pend, w_stall, w_mis;
   logic w_start_d, w_start_i, w_mis_hit;
   logic w_expired, w_to, w_drop_now, w_clr;
   logic w_unused;

   assign w_unused = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                       dm_addr[31:ADDR_W+2]};

   assign w_busy     = (r_state != IDLE);
   assign w_if_pend  = if_req & ~r_if_done;
   assign w_dm_pend  = dm_req & ~r_dm_done;
   assign w_stall    = w_if_pend | w_dm_pend;
   assign w_mis      = (dm_addr[1:0] != 2'b00);
   assign w_to       = w_expired & ~mem_ack;
   assign w_drop_now = r_drop | flush;
   assign w_clr      = ~w_busy | mem_ack | w_expired;

   arb_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clock   (clock),
      .reset   (reset),
      .clr     (w_clr),
      .en      (w_busy),
      .expired (w_expired)
   );

   assign stall        = w_stall;
   assign if_valid     = r_if_done;
   assign dm_valid     = r_dm_done;
   assign if_rdata     = r_if_rdata;
   assign dm_rdata     = r_dm_rdata;
   assign mem_req      = w_busy;
   assign mem_we       = (r_state == BUSY_D) & r_we;
   assign mem_addr     = r_addr;
   assign mem_wdata    = r_wdata;
   assign err_misalign = r_err_mis;
   assign err_timeout  = r_err_to;
   assign stall_cnt    = r_stall_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Data side wins in IDLE: it belongs to the older instruction.
   always_comb begin
      w_next    = r_state;
      w_start_d = 1'b0;
      w_start_i = 1'b0;
      w_mis_hit = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_dm_pend) begin
               if (w_mis) begin
                  w_mis_hit = 1'b1;
               end else begin
                  w_next    = BUSY_D;
                  w_start_d = 1'b1;
               end
            end else if (w_if_pend) begin
               w_next    = BUSY_I;
               w_start_i = 1'b1;
            end
         end
         BUSY_D: begin
            if (mem_ack) begin
               if (w_if_pend) begin
                  w_next    = BUSY_I;
                  w_start_i = 1'b1;
               end else begin
                  w_next = IDLE;
               end
            end else if (w_expired) begin
               w_next = IDLE;
            end
         end
         BUSY_I: begin
            if (mem_ack | w_expired) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_if_done   <= 1'b0;
         r_dm_done   <= 1'b0;
         r_drop      <= 1'b0;
         r_addr      <= '0;
         r_we        <= 1'b0;
         r_wdata     <= '0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
         r_err_mis   <= 1'b0;
         r_err_to    <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_err_mis <= w_mis_hit;
         r_err_to  <= w_to;

         if (w_stall && r_stall_cnt != 32'hFFFF_FFFF) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end

         if (w_start_d) begin
            r_addr  <= dm_addr[ADDR_W+1:2];
            r_we    <= dm_we;
            r_wdata <= dm_wdata;
         end else if (w_start_i) begin
            r_addr <= if_addr[ADDR_W+1:2];
            r_we   <= 1'b0;
         end

         // A squashed fetch still runs to completion on the bus.
         if (r_state == BUSY_I) begin
            if (mem_ack | w_to) begin
               r_drop <= 1'b0;
            end else if (flush) begin
               r_drop <= 1'b1;
            end
         end else begin
            r_drop <= 1'b0;
         end

         if (!w_stall) begin
            r_if_done <= 1'b0;
         end
         if (flush) begin
            r_if_done <= 1'b0;
         end
         if (r_state == BUSY_I && (mem_ack | w_to) && !w_drop_now) begin
            r_if_done  <= 1'b1;
            r_if_rdata <= mem_ack ? mem_rdata : ERR_DATA;
         end

         if (!w_stall) begin
            r_dm_done <= 1'b0;
         end
         if (w_mis_hit) begin
            r_dm_done  <= 1'b1;
            r_dm_rdata <= ERR_DATA;
         end
         if (r_state == BUSY_D && (mem_ack | w_to)) begin
            r_dm_done <= 1'b1;
            if (w_to) begin
               r_dm_rdata <= ERR_DATA;
            end else if (!r_we) begin
               r_dm_rdata <= mem_rdata;
            end
         end
      end
   end

endmodule
